// File: rtl/ima_adpcm_pkg.sv
// ima_adpcm_pkg: shared constants, types and tables for the IMA ADPCM
// decoder and its companion encoder.
//   step_size(idx) : 89-entry IMA step table; indices above IDX_MAX read
//                    the last entry.
//   idx_delta(m)   : step-index adjustment for code magnitude m.
//   decState_e     : decoder FSM states.
package ima_adpcm_pkg;

  localparam int IDX_MAX = 88;
  localparam int PRED_W  = 19;  // predictor width, 1/8-LSB units
  localparam int SAMP_W  = 16;
  localparam int STEP_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } decState_e;

  localparam logic [STEP_W-1:0] STEP_TBL [0:IDX_MAX] = '{
        7,     8,     9,    10,    11,    12,    13,    14,    16,    17,
       19,    21,    23,    25,    28,    31,    34,    37,    41,    45,
       50,    55,    60,    66,    73,    80,    88,    97,   107,   118,
      130,   143,   157,   173,   190,   209,   230,   253,   279,   307,
      337,   371,   408,   449,   494,   544,   598,   658,   724,   796,
      876,   963,  1060,  1166,  1282,  1411,  1552,  1707,  1878,  2066,
     2272,  2499,  2749,  3024,  3327,  3660,  4026,  4428,  4871,  5358,
     5894,  6484,  7132,  7845,  8630,  9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  function automatic logic [STEP_W-1:0] step_size(input logic [6:0] idx);
    if (idx > 7'(IDX_MAX)) return STEP_TBL[IDX_MAX];
    return STEP_TBL[idx];
  endfunction

  function automatic logic signed [7:0] idx_delta(input logic [2:0] m);
    case (m)
      3'd4:    return 8'sd2;
      3'd5:    return 8'sd4;
      3'd6:    return 8'sd6;
      3'd7:    return 8'sd8;
      default: return -8'sd1;
    endcase
  endfunction

endpackage

// File: rtl/ima_adpcm_core.sv
// ima_adpcm_core: purely combinational IMA ADPCM update step.
//   pred      in  19  current predictor (signed, 1/8-LSB units)
//   index     in  7   current step index (0..88)
//   step      in  16  step size already looked up for index
//   nibble    in  4   code: bit3 sign, bits2:0 magnitude
//   pred_new  out 19  saturated new predictor
//   index_new out 7   new step index, clamped to 0..88
//   samp      out 16  rounded, saturated 16-bit sample
//   sat       out 1   predictor or sample saturation occurred
module ima_adpcm_core
  import ima_adpcm_pkg::*;
(
  input  logic signed [PRED_W-1:0] pred,
  input  logic        [6:0]        index,
  input  logic        [STEP_W-1:0] step,
  input  logic        [3:0]        nibble,
  output logic signed [PRED_W-1:0] pred_new,
  output logic        [6:0]        index_new,
  output logic        [SAMP_W-1:0] samp,
  output logic                     sat
);

  // Two guard bits: the largest pred +/- dequant overflows a 20-bit sum.
  localparam int PRE_W = PRED_W + 2;

  logic [2:0]              mag;
  logic [PRED_W-1:0]       dequant;
  logic signed [PRE_W-1:0] preSum;
  logic                    predSat;
  logic [SAMP_W:0]         rounded;
  logic                    outSat;
  logic signed [7:0]       idxSum;

  assign mag     = nibble[2:0];
  // step * (2m+1) tops out at 491505, so it fits the predictor width.
  assign dequant = PRED_W'(step) * PRED_W'({mag, 1'b1});

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    preSum = nibble[3] ? (PRE_W'(pred) - $signed({2'b00, dequant}))
                       : (PRE_W'(pred) + $signed({2'b00, dequant}));
    // The sum fits when the guard bits all equal the predictor sign bit.
    predSat = !((&preSum[PRE_W-1:PRED_W-1]) || (~|preSum[PRE_W-1:PRED_W-1]));
    if (predSat)
      pred_new = preSum[PRE_W-1] ? {1'b1, {(PRED_W-1){1'b0}}}
                                 : {1'b0, {(PRED_W-1){1'b1}}};
    else
      pred_new = preSum[PRED_W-1:0];
  end

  // Divide by 8 (floor) and round half up using bit 2. Only the positive
  // end can overflow, to exactly +32768.
  assign rounded = {pred_new[PRED_W-1], pred_new[PRED_W-1:3]} + (SAMP_W+1)'(pred_new[2]);
  assign outSat  = (rounded[SAMP_W:SAMP_W-1] == 2'b01);
  assign samp    = outSat ? {1'b0, {(SAMP_W-1){1'b1}}} : rounded[SAMP_W-1:0];
  assign sat     = predSat | outSat;

  always_comb begin
    idxSum = $signed({1'b0, index}) + idx_delta(mag);
    if (idxSum < 0)
      index_new = '0;
    else if (idxSum > $signed(8'(IDX_MAX)))
      index_new = 7'(IDX_MAX);
    else
      index_new = idxSum[6:0];
  end

endmodule

// File: rtl/ima_adpcm_dec_mc.sv
// ima_adpcm_dec_mc: multi-channel IMA ADPCM decoder, one shared datapath
// time-multiplexed over NUM_CH channels (IDLE -> CALC -> OUT per sample).
//   clock, reset            clock; synchronous active-high reset
//   in_nibble/in_ch         code and its channel, valid/ready handshake
//   in_valid/in_ready       in_ready only in IDLE with no load pending
//   load_valid/load_ch      per-channel state load, accepted in any state
//   load_samp/load_index    predictor (signed) and index (clamped to 88)
//   out_samp/out_ch         decoded sample (two's complement) and channel
//   out_valid/out_ready     output handshake, held stable until taken
//   sat_count               saturation counter, present only when the
//                           macro IMA_DEC_SAT_CNT_EN is defined
// Tags >= NUM_CH are accepted and dropped without state change or output.
module ima_adpcm_dec_mc
  import ima_adpcm_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        in_nibble,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_valid,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [SAMP_W-1:0] load_samp,
  input  logic [6:0]        load_index,
  output logic [SAMP_W-1:0] out_samp,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
`ifdef IMA_DEC_SAT_CNT_EN
  output logic [15:0]       sat_count,
`endif
  input  logic              out_ready
);

  decState_e                state;
  logic signed [PRED_W-1:0] predArr [NUM_CH];
  logic [6:0]               idxArr  [NUM_CH];
  logic [3:0]               nibReg;
  logic [CH_W-1:0]          chReg;
  logic [STEP_W-1:0]        stepReg;

  logic                     inAccept;
  logic                     inChOk;
  logic [6:0]               inIdx;
  logic signed [PRED_W-1:0] calcPred;
  logic [6:0]               calcIdx;
  logic [6:0]               loadIdx;

  logic signed [PRED_W-1:0] corePred;
  logic [6:0]               coreIdx;
  logic [SAMP_W-1:0]        coreSamp;
  logic                     coreSat;

  assign in_ready  = (state == IDLE) && !load_valid;
  assign inAccept  = in_valid && in_ready;
  assign inChOk    = 32'(in_ch) < NUM_CH;
  assign out_valid = (state == OUT);
  assign loadIdx   = (load_index > 7'(IDX_MAX)) ? 7'(IDX_MAX) : load_index;

  // Channel-indexed reads of the state array; out-of-range tags read zero.
  always_comb begin
    inIdx    = '0;
    calcPred = '0;
    calcIdx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_ch == CH_W'(i)) inIdx = idxArr[i];
      if (chReg == CH_W'(i)) begin
        calcPred = predArr[i];
        calcIdx  = idxArr[i];
      end
    end
  end

  ima_adpcm_core u_core (
    .pred      (calcPred),
    .index     (calcIdx),
    .step      (stepReg),
    .nibble    (nibReg),
    .pred_new  (corePred),
    .index_new (coreIdx),
    .samp      (coreSamp),
    .sat       (coreSat)
  );

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples values from before the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      nibReg   <= '0;
      chReg    <= '0;
      stepReg  <= '0;
      out_samp <= '0;
      out_ch   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A bad tag is consumed here and never reaches CALC.
          if (inAccept && inChOk) begin
            nibReg  <= in_nibble;
            chReg   <= in_ch;
            stepReg <= step_size(inIdx);
            state   <= CALC;
          end
        end
        CALC: begin
          out_samp <= coreSamp;
          out_ch   <= chReg;
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the channel state array is reset element by element because the
  // decoder must restart every channel from a known predictor and index;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        predArr[i] <= '0;
        idxArr[i]  <= '0;
      end else if (load_valid && load_ch == CH_W'(i)) begin
        // A load beats a CALC write-back to the same channel.
        predArr[i] <= {load_samp, 3'b000};
        idxArr[i]  <= loadIdx;
      end else if (state == CALC && chReg == CH_W'(i)) begin
        predArr[i] <= corePred;
        idxArr[i]  <= coreIdx;
      end
    end
  end

`ifdef IMA_DEC_SAT_CNT_EN
  logic [15:0] satCnt;

  always_ff @(posedge clock) begin
    if (reset)
      satCnt <= '0;
    else if (state == CALC && coreSat && satCnt != 16'hFFFF)
      satCnt <= satCnt + 16'd1;
  end

  assign sat_count = satCnt;
`else
  logic unusedSat;
  assign unusedSat = coreSat;
`endif

endmodule

// File: tb/tb_ima_adpcm_dec_mc.sv
// tb_ima_adpcm_dec_mc: self-checking bench for ima_adpcm_dec_mc with three
// channels (so tag 3 is out of range), directed cases plus random traffic
// compared against an integer reference model of the IMA decode rules.
module tb_ima_adpcm_dec_mc;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  in_nibble;
  logic [CH_W-1:0] in_ch;
  logic        in_valid;
  logic        in_ready;
  logic        load_valid;
  logic [CH_W-1:0] load_ch;
  logic [15:0] load_samp;
  logic [6:0]  load_index;
  logic [15:0] out_samp;
  logic [CH_W-1:0] out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef IMA_DEC_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  ima_adpcm_dec_mc #(.NUM_CH(NUM_CH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_nibble  (in_nibble),
    .in_ch      (in_ch),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_samp  (load_samp),
    .load_index (load_index),
    .out_samp   (out_samp),
    .out_ch     (out_ch),
    .out_valid  (out_valid),
`ifdef IMA_DEC_SAT_CNT_EN
    .sat_count  (sat_count),
`endif
    .out_ready  (out_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int stepTbl [89] = '{
        7,     8,     9,    10,    11,    12,    13,    14,    16,    17,
       19,    21,    23,    25,    28,    31,    34,    37,    41,    45,
       50,    55,    60,    66,    73,    80,    88,    97,   107,   118,
      130,   143,   157,   173,   190,   209,   230,   253,   279,   307,
      337,   371,   408,   449,   494,   544,   598,   658,   724,   796,
      876,   963,  1060,  1166,  1282,  1411,  1552,  1707,  1878,  2066,
     2272,  2499,  2749,  3024,  3327,  3660,  4026,  4428,  4871,  5358,
     5894,  6484,  7132,  7845,  8630,  9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };
  int deltaTbl [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};
  int mPred [NUM_CH];
  int mIdx  [NUM_CH];
  int mSat;

  function automatic int clampInt(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic modelDecode(input int ch, input int nib, output int samp);
    int m, dq, p, r, o;
    bit s;
    m  = nib % 8;
    dq = stepTbl[mIdx[ch]] * (2 * m + 1);
    p  = (nib >= 8) ? mPred[ch] - dq : mPred[ch] + dq;
    s  = (p > 262143) || (p < -262144);
    p  = clampInt(p, -262144, 262143);
    r  = ((p % 8) + 8) % 8;           // non-negative remainder
    o  = (p - r) / 8 + ((r >= 4) ? 1 : 0);
    if (o > 32767) s = 1'b1;
    samp = clampInt(o, -32768, 32767);
    mPred[ch] = p;
    mIdx[ch]  = clampInt(mIdx[ch] + deltaTbl[m], 0, 88);
    if (s && mSat < 65535) mSat++;
  endtask

  task automatic modelLoad(input int ch, input int samp, input int idx);
    if (ch < NUM_CH) begin
      mPred[ch] = samp * 8;
      mIdx[ch]  = (idx > 88) ? 88 : idx;
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      mPred[i] = 0;
      mIdx[i]  = 0;
    end
    mSat = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic waitReady();
    int n = 0;
    @(negedge clock);
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic loadCh(input int ch, input int samp, input int idx, input bit offer);
    @(negedge clock);
    load_valid = 1'b1;
    load_ch    = CH_W'(ch);
    load_samp  = 16'(samp);
    load_index = 7'(idx);
    if (offer) begin
      in_valid  = 1'b1;
      in_ch     = '0;
      in_nibble = 4'h7;
      #1 check("load_blocks_in_ready", in_ready, 0);
    end
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    in_valid   = 1'b0;
    modelLoad(ch, samp, idx);
    if (offer) begin
      repeat (2) begin
        @(negedge clock);
        check("load_blocked_no_out", out_valid, 0);
      end
    end
  endtask

  // One sample through the decoder: handshake, latency, optional back-
  // pressure for `hold` cycles and an optional load issued during CALC.
  task automatic decode(output int got, input int ch, input int nib, input int hold,
                        input bit ldCalc, input int ldCh, input int ldSamp, input int ldIdx);
    int expSamp;
    got = 0;
    waitReady();
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      return;
    end
    in_nibble = 4'(nib);
    in_ch     = CH_W'(ch);
    in_valid  = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    if (ch >= NUM_CH) begin
      repeat (3) begin
        @(negedge clock);
        check("bad_tag_no_out", out_valid, 0);
      end
      return;
    end
    modelDecode(ch, nib, expSamp);
    @(negedge clock);
    check("calc_no_valid", out_valid, 0);
    check("calc_in_ready", in_ready, 0);
    if (ldCalc) begin
      load_valid = 1'b1;
      load_ch    = CH_W'(ldCh);
      load_samp  = 16'(ldSamp);
      load_index = 7'(ldIdx);
    end
    @(posedge clock);
    #1 load_valid = 1'b0;
    if (ldCalc) modelLoad(ldCh, ldSamp, ldIdx);
    got = int'($signed(out_samp));
    check("out_valid", out_valid, 1);
    check("out_samp", got, expSamp);
    check("out_ch", int'(out_ch), ch);
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      in_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
      in_nibble = 4'($urandom_range(0, 15));
      @(posedge clock);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_samp", int'($signed(out_samp)), expSamp);
      check("hold_ch", int'(out_ch), ch);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check("release_idle_valid", out_valid, 0);
    check("release_idle_ready", in_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int got;
    int r;
    reset      = 1'b1;
    in_nibble  = '0;
    in_ch      = '0;
    in_valid   = 1'b0;
    load_valid = 1'b0;
    load_ch    = '0;
    load_samp  = '0;
    load_index = '0;
    out_ready  = 1'b0;

    doReset();
    check("reset_out_valid", out_valid, 0);
    check("reset_out_samp", int'(out_samp), 0);
    check("reset_out_ch", int'(out_ch), 0);
    check("reset_in_ready", in_ready, 1);
`ifdef IMA_DEC_SAT_CNT_EN
    check("reset_sat_count", int'(sat_count), 0);
`endif

    // First sample, then a negative step at the raised index.
    decode(got, 0, 7, 0, 0, 0, 0, 0);
    check("tp_first_13", got, 13);
    decode(got, 0, 15, 0, 0, 0, 0, 0);
    check("tp_neg_m17", got, -17);

    // Independent channels from reset.
    doReset();
    decode(got, 0, 7, 0, 0, 0, 0, 0);
    check("tp_ch0_13", got, 13);
    decode(got, 1, 7, 0, 0, 0, 0, 0);
    check("tp_ch1_13", got, 13);

    // Positive saturation at the top of the table.
    doReset();
    loadCh(1, 32767, 88, 0);
    decode(got, 1, 7, 0, 0, 0, 0, 0);
    check("tp_sat_7fff", got, 32767);
`ifdef IMA_DEC_SAT_CNT_EN
    check("tp_sat_count_1", int'(sat_count), 1);
`endif
    decode(got, 1, 7, 0, 0, 0, 0, 0);
    check("tp_sat_idx88", got, 32767);

    // Load index above 88 clamps; stepping down then uses index 87.
    loadCh(2, 0, 100, 1);
    decode(got, 2, 7, 0, 0, 0, 0, 0);
    decode(got, 2, 0, 0, 0, 0, 0, 0);

    // Smallest step, rounding of 7/14/21 eighths.
    loadCh(0, 0, 0, 0);
    decode(got, 0, 0, 0, 0, 0, 0, 0);
    check("tp_round_1", got, 1);
    decode(got, 0, 0, 0, 0, 0, 0, 0);
    check("tp_round_2", got, 2);
    decode(got, 0, 0, 0, 0, 0, 0, 0);
    check("tp_round_3", got, 3);

    // Backpressure: output held for 5 cycles with a competing offer.
    decode(got, 1, int'($urandom_range(0, 15)), 5, 0, 0, 0, 0);

    // Load to the channel being computed wins over its write-back.
    decode(got, 0, 5, 0, 1, 0, 1000, 0);
    decode(got, 0, 0, 0, 0, 0, 0, 0);
    check("tp_load_wins_1001", got, 1001);

    // Out-of-range tag: accepted, no output, no state change.
    decode(got, 3, 7, 0, 0, 0, 0, 0);
    decode(got, 0, 0, 0, 0, 0, 0, 0);

    // Reset while a sample is in CALC.
    waitReady();
    in_nibble = 4'h3;
    in_ch     = '0;
    in_valid  = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    repeat (3) begin
      check("reset_calc_no_out", out_valid, 0);
      @(negedge clock);
    end
    decode(got, 0, 7, 0, 0, 0, 0, 0);
    check("tp_after_reset_13", got, 13);

    // Random traffic against the model.
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)
        loadCh(int'($urandom_range(0, NUM_CH)), int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 127)), r == 0);
      else
        decode(got, int'($urandom_range(0, NUM_CH)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 2)), r == 9, int'($urandom_range(0, NUM_CH - 1)),
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 100)));
    end
`ifdef IMA_DEC_SAT_CNT_EN
    check("final_sat_count", int'(sat_count), mSat);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
